omp_run_ctrl: RTL and testbench

OMP_RUN_CTRL -- requirements
Module: omp_run_ctrl

---
 rtl/omp_run_ctrl.sv | 144 ++++++++++++++
 tb/tb_omp_run_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/omp_run_ctrl.sv
// Run sequencer for the OMP core and Block C: launches each stage, captures the support set, flags dups/timeouts.
// Launch pulse one cycle after start acceptance; run_done one cycle after the final completion or the stage timeout.
// No backpressure: start is ignored while busy and completion pulses outside their stage are dropped.
module omp_run_ctrl #(
    parameter logic [19:0] TIMEOUT = 20'd100000,
    parameter int          KMAX    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] cfg_N,
    input  logic [2:0] cfg_M,
    input  logic [4:0] cfg_K,
    output logic       start_omp,
    output logic [5:0] N_in,
    output logic [2:0] M_in,
    output logic [4:0] K_limit,
    input  logic [5:0] lambda_in,
    input  logic       lambda_we,
    input  logic [4:0] current_i_in,
    input  logic       done_omp,
    output logic       start_c,
    input  logic       done_c,
    input  logic [3:0] supp_addr,
    output logic [5:0] supp_data,
    output logic [4:0] supp_count,
    output logic       busy,
    output logic       run_done,
    output logic       err_dup,
    output logic       err_timeout
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LAUNCH_AB = 3'd1;
    localparam logic [2:0] RUN_AB    = 3'd2;
    localparam logic [2:0] LAUNCH_C  = 3'd3;
    localparam logic [2:0] RUN_C     = 3'd4;
    localparam logic [2:0] FIN       = 3'd5;
    localparam logic [2:0] ERR       = 3'd6;

    logic [2:0]  state;
    logic [19:0] timer;
    logic [5:0]  supp_mem [KMAX];
    logic [4:0]  k_eff;
    logic        capture;
    logic        dup_hit;
    logic        stage_expired;

    assign k_eff         = (cfg_K > 5'(KMAX)) ? 5'(KMAX) : cfg_K;
    assign capture       = (state == RUN_AB) && lambda_we && (supp_count < K_limit);
    assign stage_expired = (timer == TIMEOUT - 20'd1);

    // Only entries already captured in this run take part in the duplicate search.
    always_comb begin
        dup_hit = 1'b0;
        for (int i = 0; i < KMAX; i++) begin
            if ((5'(i) < supp_count) && (supp_mem[i] == lambda_in)) begin
                dup_hit = 1'b1;
            end
        end
    end

    assign start_omp = (state == LAUNCH_AB);
    assign start_c   = (state == LAUNCH_C);
    assign run_done  = (state == FIN) || (state == ERR);
    assign busy      = (state != IDLE);
    assign supp_data = supp_mem[supp_addr];

    always_ff @(posedge clk) begin
        if (capture) begin
            supp_mem[supp_count[3:0]] <= lambda_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            timer       <= '0;
            supp_count  <= '0;
            N_in        <= '0;
            M_in        <= '0;
            K_limit     <= '0;
            err_dup     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        N_in        <= cfg_N;
                        M_in        <= cfg_M;
                        K_limit     <= k_eff;
                        supp_count  <= '0;
                        err_dup     <= 1'b0;
                        err_timeout <= 1'b0;
                        state       <= (cfg_K == 5'd0) ? FIN : LAUNCH_AB;
                    end
                end
                LAUNCH_AB: begin
                    timer <= '0;
                    state <= RUN_AB;
                end
                RUN_AB: begin
                    // Capture completes even on the cycle done_omp arrives.
                    if (capture) begin
                        supp_count <= supp_count + 5'd1;
                        if (dup_hit) begin
                            err_dup <= 1'b1;
                        end
                    end
                    if (done_omp) begin
                        state <= LAUNCH_C;
                    end else if (stage_expired) begin
                        err_timeout <= 1'b1;
                        state       <= ERR;
                    end else begin
                        timer <= timer + 20'd1;
                    end
                end
                LAUNCH_C: begin
                    timer <= '0;
                    state <= RUN_C;
                end
                RUN_C: begin
                    if (done_c) begin
                        state <= FIN;
                    end else if (stage_expired) begin
                        err_timeout <= 1'b1;
                        state       <= ERR;
                    end else begin
                        timer <= timer + 20'd1;
                    end
                end
                FIN:     state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    // The core's own index is informational; record runs where it disagrees with ours.
    cover property (@(posedge clk) disable iff (!rst_n) capture && (current_i_in != supp_count));
`endif

endmodule

// File: tb/tb_omp_run_ctrl.sv
// Bench for omp_run_ctrl: planned runs scored against an abstract per-run model, checked by a run_done monitor.
module tb_omp_run_ctrl;
    localparam int TO = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start;
    logic [5:0] cfg_N;
    logic [2:0] cfg_M;
    logic [4:0] cfg_K;
    logic       start_omp;
    logic [5:0] N_in;
    logic [2:0] M_in;
    logic [4:0] K_limit;
    logic [5:0] lambda_in;
    logic       lambda_we;
    logic [4:0] current_i_in;
    logic       done_omp;
    logic       start_c;
    logic       done_c;
    logic [3:0] supp_addr;
    logic [5:0] supp_data;
    logic [4:0] supp_count;
    logic       busy;
    logic       run_done;
    logic       err_dup;
    logic       err_timeout;

    omp_run_ctrl #(.TIMEOUT(20'd50), .KMAX(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_N(cfg_N), .cfg_M(cfg_M), .cfg_K(cfg_K),
        .start_omp(start_omp), .N_in(N_in), .M_in(M_in), .K_limit(K_limit),
        .lambda_in(lambda_in), .lambda_we(lambda_we), .current_i_in(current_i_in), .done_omp(done_omp),
        .start_c(start_c), .done_c(done_c), .supp_addr(supp_addr), .supp_data(supp_data),
        .supp_count(supp_count), .busy(busy), .run_done(run_done), .err_dup(err_dup),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t0; int lat; int dup; int to; int cnt; int klim; int n; int m; int n_omp; int n_c;
    } exp_t;

    exp_t       sb[$];
    exp_t       me;
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         p_omp = 0;
    int         p_c = 0;
    bit         we_a[1:TO];
    logic [5:0] lam_a[1:TO];
    int         D;
    int         Dc;
    logic [5:0] mbuf[16];
    int         rk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        start = 1'b0; lambda_we = 1'b0; lambda_in = '0; current_i_in = '0;
        done_omp = 1'b0; done_c = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_start_omp"}, int'(start_omp), 0);
        chk({tag, "_start_c"}, int'(start_c), 0);
        chk({tag, "_run_done"}, int'(run_done), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_err_dup"}, int'(err_dup), 0);
        chk({tag, "_err_timeout"}, int'(err_timeout), 0);
        chk({tag, "_supp_count"}, int'(supp_count), 0);
        chk({tag, "_N_in"}, int'(N_in), 0);
        chk({tag, "_M_in"}, int'(M_in), 0);
        chk({tag, "_K_limit"}, int'(K_limit), 0);
    endtask

    task automatic clear_plan();
        for (int c = 1; c <= TO; c++) begin
            we_a[c] = 1'b0;
            lam_a[c] = '0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: counts launch pulses and scores every run_done against the queued expectation.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            p_omp = 0;
            p_c = 0;
        end else begin
            if (start_omp) p_omp++;
            if (start_c) p_c++;
            if (run_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_run_done", 1, 0);
                end else begin
                    me = sb.pop_front();
                    chk("latency", cyc - me.t0, me.lat);
                    chk("err_dup", int'(err_dup), me.dup);
                    chk("err_timeout", int'(err_timeout), me.to);
                    chk("supp_count", int'(supp_count), me.cnt);
                    chk("K_limit", int'(K_limit), me.klim);
                    chk("N_in", int'(N_in), me.n);
                    chk("M_in", int'(M_in), me.m);
                    chk("start_omp_cycles", p_omp, me.n_omp);
                    chk("start_c_cycles", p_c, me.n_c);
                end
                p_omp = 0;
                p_c = 0;
            end
        end
    end

    // One run: model the plan (we_a/lam_a, D, Dc), queue the expectation, then drive it.
    task automatic run(input int n, input int m, input int k, input bit abort_c);
        exp_t       e;
        logic [5:0] st[$];
        int         ab_end;
        int         c_end;
        bit         ok;
        e.n = n; e.m = m; e.klim = (k > 16) ? 16 : k;
        e.dup = 0; e.to = 0; e.n_omp = 0; e.n_c = 0;
        ab_end = (D <= TO) ? D : TO;
        c_end = (Dc <= TO) ? Dc : TO;
        if (e.klim == 0) begin
            e.lat = 1;
        end else begin
            e.n_omp = 1;
            for (int c = 1; c <= ab_end; c++) begin
                if (we_a[c] && st.size() < e.klim) begin
                    foreach (st[j]) if (st[j] == lam_a[c]) e.dup = 1;
                    st.push_back(lam_a[c]);
                end
            end
            if (D > TO) begin
                e.to = 1;
                e.lat = TO + 2;
            end else begin
                e.n_c = 1;
                if (Dc > TO) e.to = 1;
                e.lat = 3 + D + c_end;
            end
        end
        e.cnt = st.size();
        foreach (st[j]) mbuf[j] = st[j];

        @(negedge clk);
        e.t0 = cyc;
        if (!abort_c) sb.push_back(e);
        start = 1'b1; cfg_N = 6'(n); cfg_M = 3'(m); cfg_K = 5'(k);
        @(negedge clk);
        start = 1'b0; cfg_N = 6'($urandom); cfg_M = 3'($urandom); cfg_K = 5'($urandom);
        if (e.klim > 0) begin
            ok = 0;
            for (int i = 0; i < 4 && !ok; i++) begin
                if (start_omp) ok = 1; else @(negedge clk);
            end
            if (!ok) begin
                chk("start_omp_seen", 0, 1);
            end else begin
                for (int c = 1; c <= ab_end; c++) begin
                    @(negedge clk);
                    lambda_we = we_a[c]; lambda_in = lam_a[c]; current_i_in = 5'($urandom);
                    done_omp = (c == D); done_c = ($urandom_range(0, 5) == 0);
                    start = ($urandom_range(0, 7) == 0); cfg_K = 5'($urandom);
                end
                @(negedge clk);
                idle_inputs();
                if (D <= TO) begin
                    ok = 0;
                    for (int i = 0; i < 4 && !ok; i++) begin
                        if (start_c) ok = 1; else @(negedge clk);
                    end
                    if (!ok) chk("start_c_seen", 0, 1);
                    for (int c = 1; ok && c <= c_end; c++) begin
                        @(negedge clk);
                        if (abort_c && c == 4) begin
                            rst_n = 1'b0;
                            #1;
                            chk_reset_outs("abort");
                            break;
                        end
                        done_c = (c == Dc); done_omp = ($urandom_range(0, 3) == 0);
                        start = ($urandom_range(0, 3) == 0); cfg_N = 6'($urandom);
                        cfg_M = 3'($urandom); cfg_K = 5'($urandom);
                    end
                    @(negedge clk);
                    idle_inputs();
                    if (abort_c) begin
                        @(negedge clk);
                        rst_n = 1'b1;
                    end
                end
            end
        end
        ok = 0;
        for (int i = 0; i < 120 && !ok; i++) begin
            if (!busy) ok = 1; else @(negedge clk);
        end
        chk("busy_drops", int'(ok), 1);
        @(negedge clk);
        if (!abort_c) begin
            for (int j = 0; j < e.cnt; j++) begin
                supp_addr = 4'(j);
                #1;
                chk("supp_data", int'(supp_data), int'(mbuf[j]));
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        cfg_N = '0; cfg_M = '0; cfg_K = '0; supp_addr = '0;
        #1;
        chk_reset_outs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        clear_plan();
        for (int c = 1; c <= 16; c++) begin we_a[c] = 1'b1; lam_a[c] = 6'(3 * c); end
        D = 17; Dc = 10;
        run(63, 7, 16, 0);

        clear_plan();
        for (int c = 1; c <= 20; c++) begin we_a[c] = 1'b1; lam_a[c] = 6'(40 + c); end
        D = 21; Dc = 3;
        run(10, 2, 20, 0);

        clear_plan();
        run(5, 1, 0, 0);

        clear_plan();
        we_a[1] = 1'b1; lam_a[1] = 6'd5;
        we_a[2] = 1'b1; lam_a[2] = 6'd9;
        we_a[3] = 1'b1; lam_a[3] = 6'd5;
        D = 5; Dc = 4;
        run(1, 1, 3, 0);

        clear_plan();
        D = 99; Dc = 5;
        run(2, 3, 4, 0);

        clear_plan();
        we_a[1] = 1'b1; lam_a[1] = 6'd10;
        we_a[2] = 1'b1; lam_a[2] = 6'd11;
        we_a[3] = 1'b1; lam_a[3] = 6'd12;
        we_a[6] = 1'b1; lam_a[6] = 6'd13;
        D = 6; Dc = 2;
        run(7, 7, 4, 0);

        clear_plan();
        we_a[1] = 1'b1; lam_a[1] = 6'd1;
        D = 2; Dc = 99;
        run(9, 0, 2, 0);

        clear_plan();
        for (int c = 1; c <= 5; c++) begin we_a[c] = 1'b1; lam_a[c] = 6'(c); end
        D = 6; Dc = 30;
        run(33, 4, 8, 1);

        clear_plan();
        for (int c = 1; c <= 16; c++) begin we_a[c] = 1'b1; lam_a[c] = 6'(63 - c); end
        D = 17; Dc = 10;
        run(63, 7, 16, 0);

        for (int r = 0; r < 40; r++) begin
            for (int c = 1; c <= TO; c++) begin
                we_a[c] = ($urandom_range(0, 2) != 0);
                lam_a[c] = (r % 2 == 1) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
            end
            D = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(1, 30));
            Dc = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(1, 15));
            rk = int'($urandom_range(0, 20));
            run(int'($urandom_range(0, 63)), int'($urandom_range(0, 7)), rk, 0);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
